bcd_display_scanner: RTL

- Sequential controller for a 3-digit seven-segment display.
- Accepts an 8-bit binary value over a valid/ready handshake and converts it to 3 BCD digits with an iterative shift-add-3 (double-dabble) sequence, one bit per clock.
- Holds the result in a display register and time-multiplexes the digits onto one shared digit bus, with leading-zero blanking.
- Sits between the value producer and the shared SegDecoder instance plus the board digit enables, so a single decoder serves all three digits.

---
 rtl/bcd_display_scanner_if.sv | 19 +
 rtl/bcd_display_scanner.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/bcd_display_scanner_if.sv
// Value producer to display scanner handshake.
// Producer drives valid/data, scanner returns ready.
interface bcd_display_scanner_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/bcd_display_scanner.sv
// Binary to BCD converter (double-dabble, one bit per clock)
// feeding a multiplexed 3-digit seven-segment scanner.
module bcd_display_scanner #(
  parameter int REFRESH_DIV    = 50000,
  parameter bit BLANK_LEADING  = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_display_scanner_if.slave s_in,
  output logic                 busy,
  output logic [11:0]          bcd_out,
  output logic                 bcd_valid,
  output logic [3:0]           digit_bcd,
  output logic [2:0]           digit_sel,
  output logic                 digit_blank
);

  localparam int CW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_LOAD
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [7:0]     r_shift;
  logic [11:0]    r_acc;
  logic [3:0]     r_bitcnt;
  logic [11:0]    r_bcd;
  logic           r_bcd_valid;
  logic [CW-1:0]  r_refresh;
  logic [1:0]     r_idx;

  logic           w_ready;
  logic           w_fire;
  logic [11:0]    w_adj;
  logic [3:0]     w_digit;
  logic           w_blank;
  logic [2:0]     w_onehot;

  assign w_ready       = (r_state == S_IDLE) && !rst;
  assign w_fire        = s_in.in_valid && w_ready;
  assign s_in.in_ready = w_ready;
  assign busy          = (r_state != S_IDLE);
  assign bcd_out       = r_bcd;
  assign bcd_valid     = r_bcd_valid;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state: accept, eight shift steps, then publish
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_fire) w_next = S_CONVERT;
      S_CONVERT: if (r_bitcnt == 4'd7) w_next = S_LOAD;
      S_LOAD:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Per-nibble add-3 correction, no carry across nibbles
  always_comb begin
    w_adj = r_acc;
    for (int i = 0; i < 3; i++) begin
      if (r_acc[i*4 +: 4] >= 4'd5)
        w_adj[i*4 +: 4] = r_acc[i*4 +: 4] + 4'd3;
    end
  end

  // Conversion datapath and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift     <= '0;
      r_acc       <= '0;
      r_bitcnt    <= '0;
      r_bcd       <= '0;
      r_bcd_valid <= 1'b0;
    end else begin
      r_bcd_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fire) begin
            r_shift  <= s_in.in_data;
            r_acc    <= '0;
            r_bitcnt <= '0;
          end
        end
        S_CONVERT: begin
          r_acc    <= {w_adj[10:0], r_shift[7]};
          r_shift  <= {r_shift[6:0], 1'b0};
          r_bitcnt <= r_bitcnt + 4'd1;
        end
        S_LOAD: begin
          r_bcd       <= r_acc;
          r_bcd_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Free-running refresh divider and digit index
  always_ff @(posedge clk) begin
    if (rst) begin
      r_refresh <= '0;
      r_idx     <= 2'd0;
    end else if (r_refresh == LAST) begin
      r_refresh <= '0;
      r_idx     <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
    end else begin
      r_refresh <= r_refresh + 1'b1;
    end
  end

  // Digit mux, leading-zero blanking and enable polarity
  always_comb begin
    w_digit = r_bcd[3:0];
    unique case (1'b1)
      (r_idx == 2'd1): w_digit = r_bcd[7:4];
      (r_idx == 2'd2): w_digit = r_bcd[11:8];
      default:         w_digit = r_bcd[3:0];
    endcase
    w_blank = BLANK_LEADING &&
      (((r_idx == 2'd2) && (r_bcd[11:8] == 4'd0)) ||
       ((r_idx == 2'd1) && (r_bcd[11:4] == 8'd0)));
    w_onehot = (rst || w_blank) ? 3'b000 : (3'b001 << r_idx);
    digit_bcd   = w_digit;
    digit_blank = w_blank;
    digit_sel   = SEL_ACTIVE_LOW ? ~w_onehot : w_onehot;
  end

endmodule
